// File: rtl/sd_emmc_controller_rx_fifo.sv
// sd_emmc_controller_rx_fifo
//
// Card-to-host receive buffer that sits between the serial data receiver and
// the SDMA read path. It is a synchronous FIFO in the controller clock domain.
// It also tracks words per block and blocks per transfer, and flags when the
// programmed read transfer has been delivered.
//
// Ports
//   clock           controller clock, rising edge
//   reset           synchronous, active-low reset
//   start           one-cycle pulse that flushes the FIFO and clears counters
//                   and flags; block_count is sampled here
//   blk_words       words per block (0 is treated as 1)
//   block_count     blocks per transfer (0 is treated as 1)
//   wr_data/wr_en   push side from the data receiver
//   fifo_full       FIFO holds 2**ADDR_W words (registered)
//   is_fifo_emty_rd FIFO holds no words (registered)
//   data_read_ready pop request from the DMA
//   rd_data         popped word, valid one cycle after the pop request
//   next_data_word  one-cycle strobe: rd_data carries a new word
//   block_done      one-cycle strobe alongside the last word of a block
//   xfer_done       sticky: every block of the transfer has been delivered
//   ovf_err         sticky: push attempted while full
//   unf_err         sticky: pop attempted while empty
//
// Optional feature (macro SD_RX_FIFO_WATERMARK_EN)
//   wm_level        occupancy threshold
//   fifo_watermark  registered, high when occupancy >= wm_level
//
// The width of block_count and of the block counter comes from the BLKCNT_W
// macro. It defaults to 16 when BLKCNT_W is not defined elsewhere.

`ifndef BLKCNT_W
`define BLKCNT_W 16
`endif

module sd_emmc_controller_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [9:0]           blk_words,
  input  logic [`BLKCNT_W-1:0] block_count,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_en,
  output logic                 fifo_full,
  output logic                 is_fifo_emty_rd,
  input  logic                 data_read_ready,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 next_data_word,
  output logic                 block_done,
  output logic                 xfer_done,
  output logic                 ovf_err,
  output logic                 unf_err
`ifdef SD_RX_FIFO_WATERMARK_EN
  ,
  input  logic [ADDR_W:0]      wm_level,
  output logic                 fifo_watermark
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [DATA_W-1:0]    mem [0:DEPTH-1];

  logic [ADDR_W:0]      wptr;
  logic [ADDR_W:0]      rptr;
  logic [ADDR_W:0]      wptr_nxt;
  logic [ADDR_W:0]      rptr_nxt;
  logic [ADDR_W:0]      occ_nxt;

  logic                 push_ok;
  logic                 pop_ok;

  logic [1:0]           state;
  logic [9:0]           word_cnt;
  logic [9:0]           words_last;
  logic [`BLKCNT_W-1:0] blk_cnt;
  logic [`BLKCNT_W-1:0] blk_cnt_inc;
  logic [`BLKCNT_W-1:0] blk_total;
  logic                 count_pop;
  logic                 blk_end;

  // Flags are registered, so a pop and a push in the same cycle cannot rescue
  // each other. A push into a full FIFO is dropped. A pop from an empty FIFO
  // is refused, so there is no fall-through.
  always_comb begin
    push_ok     = wr_en & ~fifo_full;
    pop_ok      = data_read_ready & ~is_fifo_emty_rd;
    wptr_nxt    = wptr + {{ADDR_W{1'b0}}, push_ok};
    rptr_nxt    = rptr + {{ADDR_W{1'b0}}, pop_ok};
    // The extra pointer MSB makes a difference of exactly DEPTH mean "full".
    occ_nxt     = wptr_nxt - rptr_nxt;
    words_last  = (blk_words == 10'd0) ? 10'd0 : blk_words - 10'd1;
    count_pop   = pop_ok && (state == ST_ACTIVE);
    // Use >= so that a block still ends if blk_words is lowered mid-block.
    blk_end     = (word_cnt >= words_last);
    blk_cnt_inc = blk_cnt + {{(`BLKCNT_W-1){1'b0}}, 1'b1};
  end

  // Storage write: the array itself is never reset. Clearing the pointers is
  // enough to discard its contents.
  always_ff @(posedge clock) begin
    if (reset && !start && push_ok)
      mem[wptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr            <= '0;
      rptr            <= '0;
      fifo_full       <= 1'b0;
      is_fifo_emty_rd <= 1'b1;
      rd_data         <= '0;
      next_data_word  <= 1'b0;
      block_done      <= 1'b0;
      xfer_done       <= 1'b0;
      ovf_err         <= 1'b0;
      unf_err         <= 1'b0;
      word_cnt        <= '0;
      blk_cnt         <= '0;
      blk_total       <= {{(`BLKCNT_W-1){1'b0}}, 1'b1};
      state           <= ST_IDLE;
    end else if (start) begin
      // start takes priority over a push or pop in the same cycle.
      wptr            <= '0;
      rptr            <= '0;
      fifo_full       <= 1'b0;
      is_fifo_emty_rd <= 1'b1;
      next_data_word  <= 1'b0;
      block_done      <= 1'b0;
      xfer_done       <= 1'b0;
      ovf_err         <= 1'b0;
      unf_err         <= 1'b0;
      word_cnt        <= '0;
      blk_cnt         <= '0;
      blk_total       <= (block_count == '0) ? {{(`BLKCNT_W-1){1'b0}}, 1'b1}
                                             : block_count;
      state           <= ST_ACTIVE;
    end else begin
      wptr            <= wptr_nxt;
      rptr            <= rptr_nxt;
      fifo_full       <= occ_nxt[ADDR_W];
      is_fifo_emty_rd <= (occ_nxt == '0);
      next_data_word  <= pop_ok;
      block_done      <= 1'b0;

      if (wr_en && fifo_full)
        ovf_err <= 1'b1;
      if (data_read_ready && is_fifo_emty_rd)
        unf_err <= 1'b1;

      if (pop_ok)
        rd_data <= mem[rptr[ADDR_W-1:0]];

      // Pops are counted only while a transfer is active. In IDLE and DONE
      // they still move data, but the counters stay frozen.
      if (count_pop) begin
        if (blk_end) begin
          word_cnt   <= '0;
          blk_cnt    <= blk_cnt_inc;
          block_done <= 1'b1;
          if (blk_cnt_inc == blk_total) begin
            xfer_done <= 1'b1;
            state     <= ST_DONE;
          end
        end else begin
          word_cnt <= word_cnt + 10'd1;
        end
      end
    end
  end

`ifdef SD_RX_FIFO_WATERMARK_EN
  logic [ADDR_W:0] occ_after;

  always_comb begin
    occ_after = start ? '0 : occ_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      fifo_watermark <= 1'b0;
    else
      fifo_watermark <= (occ_after >= wm_level);
  end
`endif

endmodule

// File: doc/sd_emmc_controller_rx_fifo.md
Name: sd_emmc_controller_rx_fifo

Overview:
- Card-to-host data buffer feeding the SDMA engine.
- The serial data receiver pushes 32-bit words. The DMA pops them through an empty-flag / read-request handshake with a strobe on each delivered word.
- Tracks words per block and blocks per transfer, and flags completion of the programmed read transfer.
- Synchronous FIFO in the controller clock domain, between the data receiver and the DMA read path.

Parameters:
- DATA_W, 32, FIFO word width.
- ADDR_W, 4, log2 of FIFO depth (depth = 2**ADDR_W = 16 words).

Ports:
- clock  in  1  controller clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that clears the FIFO, counters and flags for a new transfer.
- blk_words  in  10  words per block; value 0 is treated as 1.
- block_count  in  `BLKCNT_W  blocks in the transfer, sampled on start; value 0 is treated as 1.
- wr_data  in  DATA_W  word from the receiver.
- wr_en  in  1  push request.
- fifo_full  out  1  FIFO holds 2**ADDR_W words.
- is_fifo_emty_rd  out  1  FIFO holds 0 words.
- data_read_ready  in  1  DMA pop request.
- rd_data  out  DATA_W  popped word.
- next_data_word  out  1  one-cycle strobe: rd_data holds a new word.
- block_done  out  1  one-cycle strobe: the last word of a block was delivered.
- xfer_done  out  1  sticky: all blocks delivered.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset==0 at an edge):
  - Pointers and occupancy cleared.
  - is_fifo_emty_rd=1.
  - fifo_full, next_data_word, block_done, xfer_done, ovf_err and unf_err all 0.
  - rd_data=0.
  - Reset mid-transfer discards all stored data.
- Storage: DATA_W x 2**ADDR_W register array.
  - Pointers are ADDR_W+1 bits wide; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2**(ADDR_W+1).
- Push: wr_en && !fifo_full writes wr_data at wptr and increments wptr.
  - wr_en && fifo_full drops the word and sets ovf_err.
- Pop: data_read_ready && !is_fifo_emty_rd at edge N.
  - rd_data is loaded from rptr and rptr increments.
  - next_data_word=1 during cycle N+1.
  - Read latency is 1 cycle.
  - rd_data holds its value until the next pop.
- Pop while empty: no pointer change, no strobe, unf_err set.
- Simultaneous push and pop:
  - Both occur when allowed; occupancy is unchanged.
  - Push while full is still rejected even if a pop occurs in the same cycle, because the flags are registered.
  - Pop while empty is rejected even if a push occurs in the same cycle, so there is no fall-through.
- Flags: both are registered and reflect occupancy after the current edge.
  - A pop makes fifo_full deassert on the next cycle.
  - The first push makes is_fifo_emty_rd deassert on the next cycle.
- Counters: word_cnt (10 bits) and blk_cnt (`BLKCNT_W bits) increment on each delivered pop.
  - When word_cnt reaches blk_words-1 on a pop: word_cnt returns to 0, blk_cnt increments, and block_done pulses in the same cycle as next_data_word.
  - When blk_cnt reaches the sampled block_count: xfer_done=1 in the cycle of the final next_data_word.
  - While xfer_done=1, further pops are still served, but the counters freeze.
- Tracker FSM: IDLE -> ACTIVE -> DONE.
  - IDLE -> ACTIVE on start.
  - ACTIVE -> DONE when the final block completes.
  - DONE -> ACTIVE on start.
  - Pops in IDLE move data but are not counted.
- Start: start has priority over push and pop in the same cycle.
  - The FIFO is flushed, errors are cleared, and block_count is sampled.
  - A push in that same cycle is discarded.

Optional Feature:
- Macro: SD_RX_FIFO_WATERMARK_EN.
- When defined, adds:
  - input wm_level[ADDR_W:0];
  - registered output fifo_watermark, high when occupancy >= wm_level, used to request DMA bursts.
  - reset value 0.
- When not defined, neither port exists and no compare logic is built.

Test Plan:
- Reset, then start with blk_words=4, block_count=2. Push 8 words 0x11..0x88 and hold data_read_ready=1.
  - Eight next_data_word strobes deliver 0x11..0x88 in order, each 1 cycle after its request.
  - block_done pulses with words 4 and 8.
  - xfer_done rises with word 8.
- Push 16 words with no pops.
  - fifo_full=1 after the 16th push.
  - A 17th push sets ovf_err=1; occupancy stays 16.
  - One pop then clears fifo_full on the following cycle.
- Pop while empty: data_read_ready=1 with is_fifo_emty_rd=1.
  - No strobe, rd_data unchanged, unf_err=1.
- Occupancy 5, wr_en and data_read_ready together for 20 cycles.
  - Occupancy stays 5; order is preserved across pointer wrap.
- Occupancy 7 mid-block, pulse start.
  - Next cycle is_fifo_emty_rd=1, counters 0, errors cleared.
- Occupancy 7, assert reset=0 for one edge.
  - All outputs at their reset values; the following pop is rejected.
